// File: rtl/dac_tx_pkg.sv
// Shared constants and FSM state type for the I2S DAC transmitter.
package dac_tx_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dac_tx_clkdiv.sv
// Bit-clock generator: divides clk by 2*BCK_DIV into bck and strobes tick
// on the cycle whose edge drives bck from 1 to 0. Held at zero while !en_i.
module dac_tx_clkdiv #(
    parameter int BCK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bck_o,
    output logic tick_o
);

    logic [7:0] div_q;
    logic       bck_q;
    logic       term;

    assign term = (div_q == 8'(BCK_DIV - 1));

    // Half-period counter; bck toggles at the terminal count.
    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else if (term) begin
            div_q <= '0;
            bck_q <= ~bck_q;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

    assign bck_o  = bck_q;
    assign tick_o = en_i && term && bck_q;

endmodule

// File: rtl/dac_i2s_tx.sv
// I2S DAC transmitter: one-pair holding register feeding a 64-bck stereo
// frame (two 32-bit slots, MSB first, one bck delay after lrck edge).
// Optional macro DAC_TX_HOLD_LAST_EN: underrun frames repeat the last loaded
// pair instead of sending zeros.
module dac_i2s_tx
    import dac_tx_pkg::*;
#(
    parameter int BCK_DIV = 4,
    parameter int DW      = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [DW-1:0] lword,
    input  logic [DW-1:0] rword,
    output logic          bck,
    output logic          lrck,
    output logic          sdata,
    output logic          underrun,
    output logic          frame_start
);

    state_e        state_q, state_d;
    logic          full_q, full_d;
    logic [DW-1:0] hold_l_q, hold_r_q;
    logic [DW-1:0] sh_l_q, sh_r_q;
    logic [5:0]    bit_cnt_q, bit_cnt_nxt;
    logic          lrck_q, sdata_q, fs_q, ur_q;
    logic          tick, load_start, wrap, take, starve, accept;
    logic          in_l, in_r, sdata_nxt;
`ifdef DAC_TX_HOLD_LAST_EN
    logic [DW-1:0] last_l_q, last_r_q;
`endif

    dac_tx_clkdiv #(.BCK_DIV(BCK_DIV)) u_clkdiv (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == RUN),
        .bck_o  (bck),
        .tick_o (tick)
    );

    assign sample_ready = !full_q && !rst;
    assign accept       = sample_valid && sample_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: leave IDLE once a pair is held; RUN is only left by reset.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q) begin
                    state_d    = RUN;
                    load_start = 1'b1;
                end
            end
            RUN: state_d = RUN;
        endcase
    end

    // Frame-boundary decisions and serial bit selection for the next slot.
    always_comb begin
        wrap        = tick && (bit_cnt_q == 6'(FRAME_BITS - 1));
        take        = load_start || (wrap && full_q);
        starve      = wrap && !full_q;
        bit_cnt_nxt = bit_cnt_q + 6'd1;
        in_l        = (bit_cnt_nxt != 6'd0) && (bit_cnt_nxt <= 6'(DW));
        in_r        = (bit_cnt_nxt >= 6'(SLOT_BITS + 1)) && (bit_cnt_nxt <= 6'(SLOT_BITS + DW));
        sdata_nxt   = 1'b0;
        if (in_l)      sdata_nxt = sh_l_q[DW-1];
        else if (in_r) sdata_nxt = sh_r_q[DW-1];
        // A load frees the holder before a same-cycle accept refills it.
        full_d = full_q;
        if (take)   full_d = 1'b0;
        if (accept) full_d = 1'b1;
    end

    // Holding register, shift registers, slot counter and serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 1'b0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            sh_l_q    <= '0;
            sh_r_q    <= '0;
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            fs_q      <= 1'b0;
            ur_q      <= 1'b0;
`ifdef DAC_TX_HOLD_LAST_EN
            last_l_q  <= '0;
            last_r_q  <= '0;
`endif
        end else begin
            full_q <= full_d;
            fs_q   <= take || starve;
            ur_q   <= starve;
            if (accept) begin
                hold_l_q <= lword;
                hold_r_q <= rword;
            end
            if (take) begin
                sh_l_q <= hold_l_q;
                sh_r_q <= hold_r_q;
`ifdef DAC_TX_HOLD_LAST_EN
                last_l_q <= hold_l_q;
                last_r_q <= hold_r_q;
`endif
            end else if (starve) begin
`ifdef DAC_TX_HOLD_LAST_EN
                sh_l_q <= last_l_q;
                sh_r_q <= last_r_q;
`else
                sh_l_q <= '0;
                sh_r_q <= '0;
`endif
            end else if (tick) begin
                if (in_l) sh_l_q <= {sh_l_q[DW-2:0], 1'b0};
                if (in_r) sh_r_q <= {sh_r_q[DW-2:0], 1'b0};
            end
            if (load_start) begin
                bit_cnt_q <= '0;
                lrck_q    <= 1'b0;
                sdata_q   <= 1'b0;
            end else if (tick) begin
                bit_cnt_q <= bit_cnt_nxt;
                lrck_q    <= bit_cnt_nxt[5];
                sdata_q   <= sdata_nxt;
            end
        end
    end

    assign lrck        = lrck_q;
    assign sdata       = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: doc/dac_i2s_tx.md
DAC_I2S_TX -- requirements
Module: dac_i2s_tx

Interface
REQ-001 SHALL have parameter BCK_DIV, default 4: clk cycles per bck half-period, legal range 1..255.
REQ-002 SHALL have parameter DW, default 24: sample width, legal range 16..31.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port sample_valid, input, 1: upstream stereo pair valid, from the ADC_iface word_ready path or any producer.
REQ-006 SHALL have port sample_ready, output, 1: holding register can accept a pair.
REQ-007 SHALL have ports lword and rword, input, DW each: left and right two's-complement samples.
REQ-008 SHALL have ports bck, lrck and sdata, output, 1 each: I2S serial DAC bus.
REQ-009 SHALL have port underrun, output, 1: one-clk pulse when a frame load finds no sample.
REQ-010 SHALL have port frame_start, output, 1: one-clk pulse at each frame load.

Function
REQ-011 SHALL hold one stereo pair in a holding register with a full flag; sample_ready = !full.
REQ-012 SHALL capture lword and rword on the same edge when sample_valid && sample_ready, and set full; inputs are ignored when ready is low.
REQ-013 SHALL run FSM states IDLE and RUN.
REQ-014 IDLE: bck=0, lrck=0, sdata=0, divider and bit counter held at 0; the FSM goes to RUN on the cycle after full first becomes 1.
REQ-015 On the IDLE->RUN transition, SHALL load the holding register into the shift register, clear full, pulse frame_start, and set bit_cnt=0.
REQ-016 RUN: the divider counts 0..BCK_DIV-1; at the terminal count bck toggles. A "tick" is each bck 1->0 transition.
REQ-017 Each tick SHALL advance bit_cnt (6 bits, 0..63), wrapping 63->0; a frame is 64 bck periods with two 32-bit slots.
REQ-018 SHALL set lrck=0 for bit_cnt 0..31 (left) and lrck=1 for bit_cnt 32..63 (right).
REQ-019 SHALL drive sdata as follows (I2S, 1-bck delay, MSB first):
  - bit_cnt 1..DW: left bit DW-bit_cnt
  - bit_cnt 33..32+DW: right bit 32+DW-bit_cnt
  - all other slots: 0
REQ-020 SHALL change sdata and lrck only on ticks, so they are stable across each bck rising edge.
REQ-021 On the 63->0 wrap tick, if full=1: load the shadow shift register, clear full, and pulse frame_start.
REQ-022 On the 63->0 wrap tick, if full=0: pulse frame_start and underrun, and handle data per REQ-028.
REQ-023 Accept and load on the same cycle: the load takes the old content first; the new pair is captured and full stays 1.
REQ-024 RUN SHALL never return to IDLE except via rst.
REQ-025 Load latency: the first accepted pair's left MSB appears on sdata at the first tick after the transition into RUN.

Reset
REQ-026 On rst, SHALL set:
  - FSM=IDLE
  - full=0, sample_ready=0 during rst then 1
  - bck=0, lrck=0, sdata=0
  - underrun=0, frame_start=0
  - divider, bit_cnt, shift and last-sample registers cleared
REQ-027 rst asserted mid-frame SHALL abort the frame immediately and discard a pending pair.

Configuration
REQ-028 Macro DAC_TX_HOLD_LAST_EN:
  - defined: an underrun frame re-transmits the last loaded pair.
  - undefined: an underrun frame transmits all-zero samples and no last-sample register exists.
  - underrun pulses in both cases.

Structure
REQ-029 SHALL place in package dac_tx_pkg:
  - SLOT_BITS=32, FRAME_BITS=64
  - FSM state typedef (IDLE, RUN)
REQ-030 SHALL contain one sub-module, dac_tx_clkdiv (divider, bck generation, tick strobe); all other logic stays in dac_i2s_tx.

Verification (BCK_DIV=1, DW=24: bck period 2 clk, frame 128 clk)
REQ-031 Reset, then idle with no valid for 50 clk -> bck=lrck=sdata=0, ready=1, no pulses.
REQ-032 One pair L=0x800001, R=0x7FFFFE -> lrck low 32 bck, sdata:
  - slot 0 = 0
  - left slots 1..24 = 1,0..0,1
  - right slots 33..56 = 0,1..1,0
  - frame_start once
REQ-033 Pairs offered every 128 clk continuously -> no underrun over 10 frames; output matches input in order.
REQ-034 No second pair after the first frame -> underrun pulse at the wrap.
  - with macro: the frame repeats the first pair.
  - without macro: the frame is all zeros.
REQ-035 sample_valid held high permanently -> ready drops after the first accept; pairs are consumed exactly one per frame with none lost or duplicated.
REQ-036 rst at bit_cnt=40 with full=1 -> next cycle IDLE, outputs 0, full=0; a new pair restarts at bit_cnt=0.
